// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - scancodes, direction and repeat-state types for the PS/2 key controller
package ps2_pkg;

    localparam logic [7:0] SC_E0       = 8'hE0;
    localparam logic [7:0] SC_UP       = 8'h75;
    localparam logic [7:0] SC_DOWN     = 8'h72;
    localparam logic [7:0] SC_LEFT     = 8'h6B;
    localparam logic [7:0] SC_RIGHT    = 8'h74;
    localparam logic [7:0] SC_SPACE    = 8'h29;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_S        = 8'h1B;
    localparam logic [7:0] SC_C        = 8'h21;
    localparam logic [7:0] SC_KP_PLUS  = 8'h79;
    localparam logic [7:0] SC_EQ       = 8'h55;
    localparam logic [7:0] SC_KP_MINUS = 8'h7B;
    localparam logic [7:0] SC_MINUS    = 8'h4E;

    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    typedef enum logic [1:0] {IDLE, DELAY, PERIOD} rep_state_t;

    function automatic logic is_arrow_code(input logic [7:0] code);
        return (code == SC_UP) || (code == SC_DOWN) ||
               (code == SC_LEFT) || (code == SC_RIGHT);
    endfunction

    function automatic dir_t arrow_dir(input logic [7:0] code);
        case (code)
            SC_UP:   return UP;
            SC_DOWN: return DOWN;
            SC_LEFT: return LEFT;
            default: return RIGHT;
        endcase
    endfunction

endpackage

// File: rtl/ps2_key_repeat.sv
// rtl/ps2_key_repeat.sv - auto-repeat FSM and down-counter for held arrow keys
module ps2_key_repeat
    import ps2_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm,
    input  logic [1:0] arm_dir,
    input  logic       cancel,
    output logic       rep_move,
    output logic [1:0] rep_dir
);

    localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
    localparam logic [CW-1:0] DLY_LOAD = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LOAD = CW'(REPEAT_PERIOD - 1);

    rep_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    dir_q, dir_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= 2'(UP);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dir_q <= dir_nxt;
        end
    end

    // Arm beats cancel beats expiry, so a move never fires in a cycle that retargets or stops the repeat.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dir_nxt   = dir_q;
        rep_move  = 1'b0;
        if (arm) begin
            state_nxt = DELAY;
            cnt_nxt   = DLY_LOAD;
            dir_nxt   = arm_dir;
        end else if (cancel) begin
            state_nxt = IDLE;
        end else if (state != IDLE) begin
            if (cnt == '0) begin
                rep_move  = 1'b1;
                state_nxt = PERIOD;
                cnt_nxt   = PER_LOAD;
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
    end

    assign rep_dir = dir_q;

endmodule

// File: rtl/ps2_key_ctrl.sv
// rtl/ps2_key_ctrl.sv - PS/2 scancode decoder driving the Life grid cursor and commands
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int         GRID_W        = 32,
    parameter int         GRID_H        = 24,
    parameter int         XW            = 5,
    parameter int         YW            = 5,
    parameter int         REPEAT_DELAY  = 25_000_000,
    parameter int         REPEAT_PERIOD = 5_000_000,
    parameter logic [2:0] SPEED_INIT    = 3'd3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    ps2_byte,
    input  logic          ps2_state,
    output logic [XW-1:0] cur_x,
    output logic [YW-1:0] cur_y,
    output logic          cmd_toggle,
    output logic          cmd_step,
    output logic          cmd_clear,
    output logic          run_en,
    output logic [2:0]    speed
);

    logic [7:0]  prev_byte;
    logic        prev_state, ext;
    logic        press, key_rel, is_e0, arrow;
    logic        arm, cancel, rep_move, move_now;
    logic [1:0]  rep_dir;
    dir_t        mv_dir;
    logic [XW:0] x_sum;
    logic [YW:0] y_sum;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    always_comb begin
        press    = ps2_state & (~prev_state | (ps2_byte != prev_byte));
        key_rel  = ~ps2_state & prev_state;
        is_e0    = (ps2_byte == SC_E0);
        arrow    = ext & is_arrow_code(ps2_byte);
        arm      = press & ~is_e0 & arrow;
        cancel   = key_rel | (press & ~is_e0 & ~arrow);
        move_now = arm | (~press & rep_move);
        mv_dir   = press ? arrow_dir(ps2_byte) : dir_t'(rep_dir);
    end

    ps2_key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_repeat (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .arm_dir (2'(arrow_dir(ps2_byte))),
        .cancel  (cancel),
        .rep_move(rep_move),
        .rep_dir (rep_dir)
    );

    // One extra bit: max+1 lands exactly on the grid size, 0-1 underflows past it.
    always_comb begin
        x_sum = {1'b0, cur_x};
        y_sum = {1'b0, cur_y};
        case (mv_dir)
            UP:      y_sum = y_sum - (YW+1)'(1);
            DOWN:    y_sum = y_sum + (YW+1)'(1);
            LEFT:    x_sum = x_sum - (XW+1)'(1);
            default: x_sum = x_sum + (XW+1)'(1);
        endcase
        if (x_sum == (XW+1)'(GRID_W))     nx = '0;
        else if (x_sum > (XW+1)'(GRID_W)) nx = XW'(GRID_W - 1);
        else                              nx = x_sum[XW-1:0];
        if (y_sum == (YW+1)'(GRID_H))     ny = '0;
        else if (y_sum > (YW+1)'(GRID_H)) ny = YW'(GRID_H - 1);
        else                              ny = y_sum[YW-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_byte  <= '0;
            prev_state <= 1'b0;
            ext        <= 1'b0;
            cur_x      <= '0;
            cur_y      <= '0;
            cmd_toggle <= 1'b0;
            cmd_step   <= 1'b0;
            cmd_clear  <= 1'b0;
            run_en     <= 1'b0;
            speed      <= SPEED_INIT;
        end else begin
            prev_byte  <= ps2_byte;
            prev_state <= ps2_state;
            cmd_toggle <= 1'b0;
            cmd_step   <= 1'b0;
            cmd_clear  <= 1'b0;
            if (move_now) begin
                cur_x <= nx;
                cur_y <= ny;
            end
            if (key_rel) ext <= 1'b0;
            if (press) begin
                if (is_e0) begin
                    ext <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    if (!ext) begin
                        case (ps2_byte)
                            SC_SPACE: cmd_toggle <= 1'b1;
                            SC_ENTER: run_en <= ~run_en;
                            SC_S:     if (!run_en) cmd_step <= 1'b1;
                            SC_C: begin
                                cmd_clear <= 1'b1;
                                run_en    <= 1'b0;
                            end
                            SC_KP_PLUS, SC_EQ:
                                if (speed != 3'd7) speed <= speed + 3'd1;
                            SC_KP_MINUS, SC_MINUS:
                                if (speed != 3'd0) speed <= speed - 3'd1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb/tb_ps2_key_ctrl.sv - scoreboard bench for ps2_key_ctrl
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] ps2_byte = 8'h00;
    logic       ps2_state = 1'b0;
    logic [4:0] cur_x, cur_y;
    logic       cmd_toggle, cmd_step, cmd_clear, run_en;
    logic [2:0] speed;

    ps2_key_ctrl #(
        .GRID_W(32), .GRID_H(24), .XW(5), .YW(5),
        .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .SPEED_INIT(3'd3)
    ) dut (
        .clk(clk), .rst(rst), .ps2_byte(ps2_byte), .ps2_state(ps2_state),
        .cur_x(cur_x), .cur_y(cur_y), .cmd_toggle(cmd_toggle), .cmd_step(cmd_step),
        .cmd_clear(cmd_clear), .run_en(run_en), .speed(speed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic       tog;
        logic       stp;
        logic       clr;
        logic       run;
        logic [2:0] spd;
    } snap_t;

    typedef struct {
        snap_t s;
        int    t;
        string name;
    } exp_t;

    exp_t  q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_pass = 0;
    bit    mon_en = 1'b0;
    snap_t last;

    logic [4:0] m_x = 5'd0;
    logic [4:0] m_y = 5'd0;
    logic       m_run = 1'b0;
    logic [2:0] m_spd = 3'd3;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic snap_t cur_snap();
        return {cur_x, cur_y, cmd_toggle, cmd_step, cmd_clear, run_en, speed};
    endfunction

    function automatic void expect_at(input string name, input int t,
                                      input logic tg, input logic st, input logic cl);
        exp_t e;
        e.s    = {m_x, m_y, tg, st, cl, m_run, m_spd};
        e.t    = t;
        e.name = name;
        q.push_back(e);
    endfunction

    function automatic void check(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endfunction

    // Any visible output change pops the next expectation and must match it in value and cycle.
    always @(negedge clk) begin
        snap_t now;
        exp_t  e;
        now = cur_snap();
        if (mon_en && now != last) begin
            n_chk++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_change got=%h at cycle %0d", now, cyc);
            end else begin
                e = q.pop_front();
                if (now === e.s && cyc == e.t) n_pass++;
                else $display("FAIL %s got=%h@%0d want=%h@%0d", e.name, now, cyc, e.s, e.t);
            end
        end
        last = now;
    end

    task automatic key(input logic [7:0] b, input logic s, output int t);
        @(negedge clk);
        ps2_byte  = b;
        ps2_state = s;
        t = cyc + 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, tp;
        logic [7:0] b;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_xy", {cur_x, cur_y}, 0);
        check("rst_run_speed", {run_en, speed}, 3);
        check("rst_pulses", {cmd_toggle, cmd_step, cmd_clear}, 0);
        last   = cur_snap();
        mon_en = 1'b1;

        key(8'hE0, 1'b1, t); key(8'h6B, 1'b1, t);
        m_x = 5'd31; expect_at("left_wrap", t, 1'b0, 1'b0, 1'b0);
        key(8'h6B, 1'b0, t);

        key(8'hE0, 1'b1, t); key(8'h75, 1'b1, t);
        m_y = 5'd23; expect_at("up_wrap", t, 1'b0, 1'b0, 1'b0);
        key(8'h75, 1'b0, t);

        key(8'hE0, 1'b1, t); key(8'h72, 1'b1, t);
        m_y = 5'd0; expect_at("down_wrap", t, 1'b0, 1'b0, 1'b0);
        key(8'h72, 1'b0, t);

        key(8'h29, 1'b1, t);
        expect_at("toggle_on", t, 1'b1, 1'b0, 1'b0);
        expect_at("toggle_off", t + 1, 1'b0, 1'b0, 1'b0);
        key(8'h29, 1'b0, t);
        repeat (3) @(negedge clk);

        key(8'hE0, 1'b1, t); key(8'h29, 1'b1, t); key(8'h29, 1'b0, t);

        key(8'h5A, 1'b1, t);
        m_run = 1'b1; expect_at("enter_run", t, 1'b0, 1'b0, 1'b0);
        key(8'h5A, 1'b0, t);
        key(8'h1B, 1'b1, t); key(8'h1B, 1'b0, t);
        key(8'h21, 1'b1, t);
        m_run = 1'b0;
        expect_at("clear_on", t, 1'b0, 1'b0, 1'b1);
        expect_at("clear_off", t + 1, 1'b0, 1'b0, 1'b0);
        key(8'h21, 1'b0, t);
        key(8'h1B, 1'b1, t);
        expect_at("step_on", t, 1'b0, 1'b1, 1'b0);
        expect_at("step_off", t + 1, 1'b0, 1'b0, 1'b0);
        key(8'h1B, 1'b0, t);

        for (int i = 0; i < 5; i++) begin
            key(8'h79, 1'b1, t);
            if (m_spd != 3'd7) begin
                m_spd = m_spd + 3'd1;
                expect_at("speed_up", t, 1'b0, 1'b0, 1'b0);
            end
            key(8'h79, 1'b0, t);
        end
        for (int i = 0; i < 8; i++) begin
            b = (i % 2 == 1) ? 8'h4E : 8'h7B;
            key(b, 1'b1, t);
            if (m_spd != 3'd0) begin
                m_spd = m_spd - 3'd1;
                expect_at("speed_down", t, 1'b0, 1'b0, 1'b0);
            end
            key(b, 1'b0, t);
        end
        key(8'h55, 1'b1, t);
        m_spd = 3'd1; expect_at("speed_eq", t, 1'b0, 1'b0, 1'b0);
        key(8'h55, 1'b0, t);

        key(8'hE0, 1'b1, t); key(8'h74, 1'b1, tp);
        m_x = 5'd0; expect_at("right_wrap_press", tp, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            m_x = 5'(i);
            expect_at("repeat_move", tp + 15 + 5 * i, 1'b0, 1'b0, 1'b0);
        end
        while (cyc < tp + 36) @(negedge clk);
        key(8'hE0, 1'b1, t);
        key(8'hE0, 1'b0, t);
        repeat (40) @(negedge clk);

        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL pending_expectations got=%0d want=0", q.size());
        check("final_x", cur_x, 4);
        check("final_run_speed", {run_en, speed}, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
